// File: rtl/frame_update_sched_pkg.sv
// Shared definitions for the Breakout per-frame update sequencer.
package frame_update_sched_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StFinish
  } state_e;

  // Named schedule slots, served in ascending order
  localparam int unsigned SLOT_PADDLE  = 0;
  localparam int unsigned SLOT_BALL    = 1;
  localparam int unsigned SLOT_COLLIDE = 2;
  localparam int unsigned SLOT_SCORE   = 3;

  // Defaults: four units, 4 ms watchdog at 100 MHz
  localparam int unsigned DefNumSlots = 4;
  localparam int unsigned DefTimeout  = 400000;

endpackage

// File: rtl/frame_update_sched_slot_watchdog.sv
// Per-slot watchdog: counts cycles while enabled, flags expiry on the TIMEOUT-th cycle.
module frame_update_sched_slot_watchdog #(
  parameter int unsigned TIMEOUT = 400000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  localparam int unsigned TimerW = $clog2(TIMEOUT);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  logic [TimerW-1:0] timer_q, timer_d;

  // Next timer value: clear wins over counting
  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (cnt_en) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Timer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired = cnt_en && (timer_q == TimerLast);

endmodule

// File: rtl/frame_update_sched.sv
// Per-frame update sequencer: on each enabled refresh tick, grants each update unit in turn.
module frame_update_sched
  import frame_update_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DefNumSlots,
  parameter int unsigned TIMEOUT   = DefTimeout,
  parameter int unsigned FCNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick60hz,
  input  logic                 enable,
  input  logic [NUM_SLOTS-1:0] done,
  input  logic                 overrun_clr,
  output logic [NUM_SLOTS-1:0] start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [FCNT_W-1:0]    frame_cnt,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [2:0]           err_slot
);

  localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_SLOTS - 1);

  state_e                 state_q, state_d;
  logic [SlotW-1:0]       slot_q, slot_d;
  logic [NUM_SLOTS-1:0]   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [2:0]             err_slot_q, err_slot_d;
  logic                   wd_expired;
  logic                   slot_done;

  frame_update_sched_slot_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == StStart),
    .cnt_en  (state_q == StWait),
    .expired (wd_expired)
  );

  assign slot_done = done[slot_q];

  // Next-state, sticky flags and registered output decode
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    err_slot_d    = err_slot_q;

    // Clear first so a same-cycle set event overrides it
    if (overrun_clr) begin
      overrun_d     = 1'b0;
      timeout_err_d = 1'b0;
    end
    if (tick60hz && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick60hz && enable) begin
          slot_d  = '0;
          state_d = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (slot_done || wd_expired) begin
          // done wins over a coincident expiry
          if (!slot_done) begin
            timeout_err_d = 1'b1;
            err_slot_d    = 3'(slot_q);
          end
          if (slot_q == LastSlot) begin
            state_d = StFinish;
          end else begin
            slot_d  = slot_q + 1'b1;
            state_d = StStart;
          end
        end
      end
      StFinish: begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they come straight off flops
    start_d = '0;
    if (state_d == StStart) begin
      start_d[slot_d] = 1'b1;
    end
    busy_d       = (state_d != StIdle);
    frame_done_d = (state_d == StFinish);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      slot_q        <= '0;
      start_q       <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      err_slot_q    <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      err_slot_q    <= err_slot_d;
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
  assign err_slot    = err_slot_q;

endmodule
